// File: rtl/cfg_pkg.sv
// Shared types and constants for the tile configuration loader.
// Field offsets describe the layout of one tile config word.
package cfg_pkg;

   localparam int CFG_W = 77;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   localparam int CLB_LSB = 54;
   localparam int CLB_W   = 23;
   localparam int CBL_LSB = 36;
   localparam int CTR_LSB = 18;
   localparam int CB_W    = 18;
   localparam int SB_LSB  = 0;
   localparam int SB_W    = 18;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      LOAD,
      WRITE,
      CSUM,
      DONE,
      ERR
   } ld_state_e;

   function automatic int nbytes(input int w);
      return (w + 7) / 8;
   endfunction

endpackage

// File: rtl/cfg_word_assembler.sv
// Collects the bytes of one config word, LSB byte first.
// The final byte is merged combinationally and its pad bits checked.
module cfg_word_assembler
   import cfg_pkg::*;
#(
   parameter int CFG_W  = 77,
   parameter int NBYTES = (CFG_W + 7) / 8,
   parameter int BW     = $clog2(NBYTES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [BW-1:0]    byte_idx,
   input  logic [7:0]       data,
   output logic [CFG_W-1:0] word,
   output logic             pad_err
);

   localparam int PAD = 8 * NBYTES - CFG_W;
   localparam logic [7:0] PAD_MASK = 8'(8'hFF << (8 - PAD));
   localparam logic [BW-1:0] LAST = BW'(NBYTES - 1);

   logic [8*(NBYTES-1)-1:0] buf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q <= '0;
      end else if (wr && byte_idx < LAST) begin
         buf_q[8*int'(byte_idx) +: 8] <= data;
      end
   end

   // the last byte never lands in buf_q; it is used straight off the bus
   assign word    = {data[7-PAD:0], buf_q};
   assign pad_err = |(data & PAD_MASK);

endmodule

// File: rtl/cfg_loader.sv
// Bitstream-to-tile configuration writer: sync, per-tile words,
// one-hot write strobes and a trailing XOR checksum.
module cfg_loader
   import cfg_pkg::*;
#(
   parameter int         NUM_TILES = 16,
   parameter int         CFG_W     = 77,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [7:0]           bs_data,
   input  logic                 bs_valid,
   output logic                 bs_ready,
   output logic [CFG_W-1:0]     cfg_bits,
   output logic [NUM_TILES-1:0] tile_wr_en,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int NBYTES = (CFG_W + 7) / 8;
   localparam int TW     = $clog2(NUM_TILES + 1);
   localparam int BW     = $clog2(NBYTES + 1);

   localparam logic [TW-1:0] LAST_TILE = TW'(NUM_TILES - 1);
   localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
   localparam logic [NUM_TILES-1:0] ONE = {{(NUM_TILES-1){1'b0}}, 1'b1};

   ld_state_e        state;
   logic [TW-1:0]    tile_idx;
   logic [BW-1:0]    byte_idx;
   logic [7:0]       csum;
   logic [CFG_W-1:0] word;
   logic             pad_err;
   logic             acc;

   assign acc = bs_valid & bs_ready;

   cfg_word_assembler #(
      .CFG_W  (CFG_W),
      .NBYTES (NBYTES),
      .BW     (BW)
   ) u_asm (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (acc && state == LOAD),
      .byte_idx (byte_idx),
      .data     (bs_data),
      .word     (word),
      .pad_err  (pad_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tile_idx   <= '0;
         byte_idx   <= '0;
         csum       <= '0;
         cfg_bits   <= '0;
         tile_wr_en <= '0;
         bs_ready   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         tile_wr_en <= '0;
         unique case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state    <= SYNC;
                  tile_idx <= '0;
                  byte_idx <= '0;
                  csum     <= '0;
                  bs_ready <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
               end
            end
            SYNC: begin
               if (acc && bs_data == SYNC_BYTE) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (acc) begin
                  csum <= csum ^ bs_data;
                  if (byte_idx != LAST_BYTE) begin
                     byte_idx <= byte_idx + 1'b1;
                  end else if (pad_err) begin
                     state    <= ERR;
                     bs_ready <= 1'b0;
                     busy     <= 1'b0;
                     err      <= 1'b1;
                  end else begin
                     state      <= WRITE;
                     byte_idx   <= '0;
                     cfg_bits   <= word;
                     tile_wr_en <= ONE << tile_idx;
                     bs_ready   <= 1'b0;
                  end
               end
            end
            WRITE: begin
               tile_idx <= tile_idx + 1'b1;
               bs_ready <= 1'b1;
               state    <= (tile_idx < LAST_TILE) ? LOAD : CSUM;
            end
            CSUM: begin
               if (acc) begin
                  bs_ready <= 1'b0;
                  busy     <= 1'b0;
                  if (bs_data == csum) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ERR;
                     err   <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               bs_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed-plus-random bench for cfg_loader with a 4-tile fabric model.
// Frames and expected words are built from the byte-stream format.
module tb_cfg_loader;
   import cfg_pkg::*;

   localparam int NT = 4;
   localparam int NB = (CFG_W + 7) / 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [7:0]       bs_data = 8'h00;
   logic             bs_valid = 1'b0;
   logic             bs_ready;
   logic [CFG_W-1:0] cfg_bits;
   logic [NT-1:0]    tile_wr_en;
   logic             busy;
   logic             done;
   logic             err;

   cfg_loader #(
      .NUM_TILES (NT),
      .CFG_W     (CFG_W),
      .SYNC_BYTE (SYNC_BYTE)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .bs_data    (bs_data),
      .bs_valid   (bs_valid),
      .bs_ready   (bs_ready),
      .cfg_bits   (cfg_bits),
      .tile_wr_en (tile_wr_en),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nfail = 0;

   logic [7:0]       wb [NT][NB];
   logic [CFG_W-1:0] exp_w [NT];
   logic [CFG_W-1:0] tile_mem [NT];
   logic [7:0]       frame [$];
   int               log_q [$];

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // tile fabric: a strobe seen low-phase is captured on the next edge
   always @(negedge clk) begin : tile_model
      int idx;
      if (rst_n && tile_wr_en != '0) begin
         idx = -1;
         for (int i = 0; i < NT; i++)
            if (tile_wr_en[i]) idx = i;
         chk("wr_onehot", 128'($onehot(tile_wr_en)), 128'(1));
         chk("wr_ready_low", 128'(bs_ready), 128'(0));
         if (idx >= 0) begin
            tile_mem[idx] = cfg_bits;
            chk($sformatf("tile%0d_bits", idx), 128'(tile_mem[idx]),
                128'(exp_w[idx]));
         end
         log_q.push_back(idx);
      end
   end

   function automatic void make_words(input bit rnd);
      for (int t = 0; t < NT; t++)
         for (int k = 0; k < NB; k++) begin
            wb[t][k] = rnd ? 8'($urandom) : 8'(8'h11 * (t + 1));
            if (k == NB - 1) wb[t][k] = wb[t][k] & 8'h1F;
         end
   endfunction

   function automatic void build(input int njunk, input logic [7:0] flip,
                                 input int bad_tile);
      logic [8*NB-1:0] full;
      logic [7:0] cs;
      logic [7:0] junk [3];
      junk[0] = 8'h00;
      junk[1] = 8'hFF;
      junk[2] = 8'h3C;
      frame.delete();
      cs = 8'h00;
      for (int j = 0; j < njunk; j++) frame.push_back(junk[j]);
      frame.push_back(SYNC_BYTE);
      for (int t = 0; t < NT; t++) begin
         full = '0;
         for (int k = 0; k < NB; k++) begin
            full = full | ((8*NB)'(wb[t][k]) << (8 * k));
            cs = cs ^ wb[t][k];
         end
         exp_w[t] = full[CFG_W-1:0];
         for (int k = 0; k < NB; k++) begin
            if (t == bad_tile && k == NB - 1) begin
               frame.push_back(8'hE0);
               return;
            end
            frame.push_back(wb[t][k]);
         end
      end
      frame.push_back(cs ^ flip);
   endfunction

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input int gap, input int start_at, input int limit);
      bit acc;
      bit r;
      int cyc;
      int n;
      n = (limit < frame.size()) ? limit : frame.size();
      for (int i = 0; i < n; i++) begin
         acc = 1'b0;
         cyc = 0;
         while (!acc && cyc <= 200) begin
            @(negedge clk);
            bs_data  = frame[i];
            bs_valid = ($urandom_range(0, 99) >= gap);
            start    = (i == start_at) && bs_valid;
            r        = bs_ready;
            @(posedge clk);
            acc = bs_valid && r;
            cyc++;
         end
         if (!acc) begin
            chk("accept_timeout", 128'(acc), 128'(1));
            break;
         end
      end
      @(negedge clk);
      bs_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic check_end(input string tag, input bit exp_done,
                            input bit exp_err, input int npulse);
      repeat (2) @(negedge clk);
      chk({tag, "_done"}, 128'(done), 128'(exp_done));
      chk({tag, "_err"}, 128'(err), 128'(exp_err));
      chk({tag, "_ready"}, 128'(bs_ready), 128'(0));
      chk({tag, "_busy"}, 128'(busy), 128'(0));
      chk({tag, "_npulse"}, 128'(log_q.size()), 128'(npulse));
      for (int i = 0; i < log_q.size() && i < npulse; i++)
         chk($sformatf("%s_pulse%0d", tag, i), 128'(log_q[i]), 128'(i));
      log_q.delete();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_cfg"}, 128'(cfg_bits), 128'(0));
      chk({tag, "_wr"}, 128'(tile_wr_en), 128'(0));
      chk({tag, "_ready"}, 128'(bs_ready), 128'(0));
      chk({tag, "_busy"}, 128'(busy), 128'(0));
      chk({tag, "_done"}, 128'(done), 128'(0));
      chk({tag, "_err"}, 128'(err), 128'(0));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      make_words(1'b0);
      build(0, 8'h00, -1);
      do_start();
      chk("busy_after_start", 128'(busy), 128'(1));
      chk("ready_in_sync", 128'(bs_ready), 128'(1));
      send(0, -1, 1000);
      check_end("t1", 1'b1, 1'b0, NT);

      build(0, 8'h01, -1);
      do_start();
      send(0, -1, 1000);
      check_end("t2", 1'b0, 1'b1, NT);

      build(0, 8'h00, 2);
      do_start();
      send(0, -1, 1000);
      check_end("t3", 1'b0, 1'b1, 2);

      build(3, 8'h00, -1);
      do_start();
      send(30, -1, 1000);
      check_end("t4", 1'b1, 1'b0, NT);

      build(0, 8'h00, -1);
      do_start();
      send(0, -1, 1 + NB + 5);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("t5_rst");
      @(negedge clk);
      rst_n = 1'b1;
      log_q.delete();
      do_start();
      send(20, -1, 1000);
      check_end("t5", 1'b1, 1'b0, NT);

      for (int rep = 0; rep < 3; rep++) begin
         make_words(1'b1);
         build(rep, 8'h00, -1);
         do_start();
         send(30, 3 + 7 * rep, 1000);
         check_end($sformatf("t6_%0d", rep), 1'b1, 1'b0, NT);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
